// File: rtl/dmem_mmio.sv
// Data memory stage: word RAM with combinational loads, plus MMIO timer and a
// TX byte FIFO drained over a valid/ready stream.
module dmem_mmio #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] timer_out
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam logic [29:0] TIMER_A  = MMIO_BASE[31:2];
    localparam logic [29:0] TXDATA_A = MMIO_BASE[31:2] + 30'd1;
    localparam logic [29:0] STATUS_A = MMIO_BASE[31:2] + 30'd2;
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    logic [31:0]   ram_r [RAM_WORDS];
    logic [7:0]    fifo_r [FIFO_DEPTH];
    logic [31:0]   timer_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          overflow_r;

    logic [29:0]   word_a_s;
    logic [AW-1:0] ram_idx_s;
    logic          ram_hit_s;
    logic          timer_hit_s;
    logic          txdata_hit_s;
    logic          status_hit_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          push_s;
    logic          push_ok_s;
    logic          ovf_set_s;
    logic          ovf_clr_s;
    logic [CW-1:0] count_nxt_s;
    logic [31:0]   status_s;
    logic [31:0]   read_data_s;

    assign word_a_s     = Mem_WrAddr[31:2];
    assign ram_idx_s    = Mem_WrAddr[AW+1:2];
    assign ram_hit_s    = (Mem_WrAddr < RAM_BYTES);
    assign timer_hit_s  = (word_a_s == TIMER_A);
    assign txdata_hit_s = (word_a_s == TXDATA_A);
    assign status_hit_s = (word_a_s == STATUS_A);

    assign full_s    = (count_r == CNT_FULL);
    assign empty_s   = (count_r == {CW{1'b0}});
    assign pop_s     = !empty_s && tx_ready;
    assign push_s    = MemWrite && txdata_hit_s;
    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign push_ok_s = push_s && (!full_s || pop_s);
    assign ovf_set_s = push_s && full_s && !pop_s;
    assign ovf_clr_s = MemWrite && status_hit_s;

    assign status_s = {16'h0000, 8'(count_r), 5'b00000, overflow_r, empty_s, full_s};

    // Occupancy update from the accepted push and pop of this edge.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Load path: combinational decode of the current address.
    always_comb begin
        read_data_s = 32'h0000_0000;
        if (ram_hit_s) begin
            read_data_s = ram_r[ram_idx_s];
        end else if (timer_hit_s) begin
            read_data_s = timer_r;
        end else if (status_hit_s) begin
            read_data_s = status_s;
        end else begin
            read_data_s = 32'h0000_0000;
        end
    end

    // RAM store port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && MemWrite && ram_hit_s) begin
            ram_r[ram_idx_s] <= Mem_WrData;
        end
    end

    // FIFO storage; cleared on reset so the idle head byte reads as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_r[i] <= 8'h00;
            end
        end else if (push_ok_s) begin
            fifo_r[wr_ptr_r] <= Mem_WrData[7:0];
        end
    end

    // Timer, FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r    <= 32'h0000_0000;
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            timer_r  <= (MemWrite && timer_hit_s) ? Mem_WrData : timer_r + 32'd1;
            count_r  <= count_nxt_s;
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            // A new overflow event outranks a clear on the same edge.
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign ReadData  = read_data_s;
    assign tx_valid  = !empty_s;
    assign tx_data   = fifo_r[rd_ptr_r];
    assign timer_out = timer_r;

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized plus directed bench for dmem_mmio; a queue-based reference model
// feeds a scoreboard that a negedge monitor drains.
module tb_dmem_mmio;

    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [31:0] TXDATA = 32'hFFFF_0004;
    localparam logic [31:0] STATUS = 32'hFFFF_0008;
    localparam logic [31:0] RAM_BYTES = 32'h0000_1000;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] Mem_WrAddr = 32'h0;
    logic [31:0] Mem_WrData = 32'h0;
    logic        tx_ready = 1'b0;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [31:0] timer_out;

    dmem_mmio #(.RAM_WORDS(1024), .FIFO_DEPTH(8), .MMIO_BASE(32'hFFFF_0000)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Mem_WrAddr(Mem_WrAddr),
        .Mem_WrData(Mem_WrData), .ReadData(ReadData), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .timer_out(timer_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        bit          chk_rd;
        logic [31:0] tmr;
        bit          vld;
        bit          chk_txd;
    } exp_t;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_ram [int];
    logic [31:0] m_timer = 32'h0;
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;
    bit          m_fresh = 1'b1;
    logic [7:0]  sb_q [$];
    exp_t        exp_q [$];
    exp_t        mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // What the outputs must show this cycle, from the model state and the current address.
    function automatic exp_t make_exp();
        exp_t e;
        logic [29:0] a;
        a = Mem_WrAddr[31:2];
        e.rd = 32'h0;
        e.chk_rd = 1'b1;
        if (Mem_WrAddr < RAM_BYTES) begin
            if (m_ram.exists(int'(a))) e.rd = m_ram[int'(a)];
            else e.chk_rd = 1'b0;
        end else if (a == BASE[31:2]) begin
            e.rd = m_timer;
        end else if (a == STATUS[31:2]) begin
            e.rd = {16'h0000, 8'(m_cnt), 5'b00000, m_ovf, (m_cnt == 0), (m_cnt == D)};
        end
        e.tmr = m_timer;
        e.vld = (m_cnt != 0);
        e.chk_txd = m_fresh && (m_cnt == 0);
        return e;
    endfunction

    // Advance the model by one edge using the inputs presented at that edge.
    task automatic step_model();
        bit pop;
        logic [29:0] a;
        if (reset) begin
            m_timer = 32'h0;
            m_cnt = 0;
            m_ovf = 1'b0;
            m_fresh = 1'b1;
            sb_q.delete();
        end else begin
            a = Mem_WrAddr[31:2];
            pop = (m_cnt > 0) && tx_ready;
            if (MemWrite && a == BASE[31:2]) m_timer = Mem_WrData;
            else m_timer = m_timer + 32'd1;
            if (MemWrite && Mem_WrAddr < RAM_BYTES) m_ram[int'(a)] = Mem_WrData;
            if (pop) m_cnt--;
            if (MemWrite && a == TXDATA[31:2]) begin
                if (m_cnt < D) begin
                    m_cnt++;
                    sb_q.push_back(Mem_WrData[7:0]);
                    m_fresh = 1'b0;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (MemWrite && a == STATUS[31:2]) begin
                m_ovf = 1'b0;
            end
        end
    endtask

    task automatic drive(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input bit rdy, input bit rst);
        MemWrite = w;
        Mem_WrAddr = a;
        Mem_WrData = d;
        tx_ready = rdy;
        reset = rst;
        exp_q.push_back(make_exp());
    endtask

    task automatic tick();
        @(posedge clk);
        step_model();
        #1;
    endtask

    task automatic cyc(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit rdy, input bit rst);
        drive(w, a, d, rdy, rst);
        tick();
    endtask

    task automatic rd_chk(input string n, input logic [31:0] a, input logic [31:0] v, input bit rdy);
        drive(1'b0, a, 32'h0, rdy, 1'b0);
        #2;
        chk(n, ReadData, v);
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0, 1:    rand_addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            2:       rand_addr = ($urandom_range(0, 1) == 0) ? 32'h0000_0FFC : 32'h0000_1000;
            3:       rand_addr = BASE;
            4, 7:    rand_addr = TXDATA;
            5:       rand_addr = STATUS;
            default: rand_addr = ($urandom_range(0, 1) == 0) ? 32'hFFFF_000C : 32'h0000_2000;
        endcase
    endfunction

    // Monitor: per-cycle expectations plus the byte stream against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk_rd) chk("read_data", ReadData, mon_e.rd);
                chk("timer_out", timer_out, mon_e.tmr);
                chk("tx_valid", {31'h0, tx_valid}, {31'h0, mon_e.vld});
                if (mon_e.chk_txd) chk("tx_data_idle", {24'h0, tx_data}, 32'h0);
            end
            if (!reset && tx_valid && tx_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("tx_byte", {24'h0, tx_data}, {24'h0, sb_q.pop_front()});
                end
            end
        end
    end

    initial begin
        repeat (2) begin
            @(posedge clk);
            step_model();
        end
        #1;
        cyc(1'b0, BASE, 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) cyc(1'b0, BASE, 32'h0, 1'b0, 1'b0);
        rd_chk("timer_after_5", BASE, 32'd5, 1'b0);

        cyc(1'b1, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
        rd_chk("ram_0x10", 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        rd_chk("ram_0x13", 32'h0000_0013, 32'hDEAD_BEEF, 1'b0);
        rd_chk("ram_oob_read", 32'h0000_1000, 32'h0, 1'b0);
        cyc(1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0, 1'b0);
        rd_chk("ram_oob_store_w0", 32'h0000_0000, 32'h0BAD_F00D, 1'b0);
        rd_chk("ram_oob_store_w4", 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);

        cyc(1'b1, BASE, 32'hFFFF_FFFE, 1'b0, 1'b0);
        rd_chk("timer_fffe", BASE, 32'hFFFF_FFFE, 1'b0);
        rd_chk("timer_ffff", BASE, 32'hFFFF_FFFF, 1'b0);
        rd_chk("timer_wrap", BASE, 32'h0, 1'b0);

        cyc(1'b1, TXDATA, 32'h0000_0041, 1'b0, 1'b0);
        cyc(1'b1, TXDATA, 32'h0000_0042, 1'b0, 1'b0);
        cyc(1'b1, TXDATA, 32'h0000_0043, 1'b0, 1'b0);
        drive(1'b0, STATUS, 32'h0, 1'b0, 1'b0);
        #2;
        chk("status_three", ReadData, 32'h0000_0300);
        chk("head_byte", {24'h0, tx_data}, 32'h41);
        tick();
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0000_2000, 32'h0, 1'b1, 1'b0);
        drive(1'b0, STATUS, 32'h0, 1'b0, 1'b0);
        #2;
        chk("status_drained", ReadData, 32'h0000_0002);
        chk("valid_low", {31'h0, tx_valid}, 32'h0);
        tick();

        for (int i = 0; i < 9; i++) cyc(1'b1, TXDATA, 32'(8'h60 + i), 1'b0, 1'b0);
        rd_chk("status_overflow", STATUS, 32'h0000_0805, 1'b0);
        cyc(1'b1, STATUS, 32'hFFFF_FFFF, 1'b0, 1'b0);
        rd_chk("status_ovf_clear", STATUS, 32'h0000_0801, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0000_2000, 32'h0, 1'b1, 1'b0);
        rd_chk("status_after_ovf", STATUS, 32'h0000_0002, 1'b0);

        for (int i = 0; i < 8; i++) cyc(1'b1, TXDATA, 32'(8'h70 + i), 1'b0, 1'b0);
        cyc(1'b1, TXDATA, 32'h0000_0055, 1'b1, 1'b0);
        rd_chk("full_push_pop", STATUS, 32'h0000_0801, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0000_2000, 32'h0, 1'b1, 1'b0);
        rd_chk("status_after_pp", STATUS, 32'h0000_0002, 1'b0);

        for (int i = 0; i < 4; i++) cyc(1'b1, TXDATA, 32'(8'hA0 + i), 1'b0, 1'b0);
        cyc(1'b1, BASE, 32'd100, 1'b0, 1'b0);
        drive(1'b1, TXDATA, 32'h0000_00EE, 1'b1, 1'b1);
        #2;
        chk("timer_before_rst", timer_out, 32'd100);
        tick();
        drive(1'b0, STATUS, 32'h0, 1'b0, 1'b0);
        #2;
        chk("rst_status", ReadData, 32'h0000_0002);
        chk("rst_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_timer", timer_out, 32'h0);
        chk("rst_txdata", {24'h0, tx_data}, 32'h0);
        tick();
        rd_chk("rst_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 1) == 1), rand_addr(), $urandom,
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
        end
        for (int i = 0; i < 12; i++) cyc(1'b0, 32'h0000_2000, 32'h0, 1'b1, 1'b0);
        chk("drain_empty", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory stage directly downstream of the single-cycle core.
- Consumes the core's MemWrite, Mem_WrAddr and Mem_WrData, and returns ReadData combinationally in the same cycle.
- Contains a word RAM plus a small MMIO block:
  - free-running 32-bit timer;
  - TX FIFO drained through a valid/ready byte-stream port that feeds a UART or debug sink.

Parameters:
RAM_WORDS, 1024, RAM depth in 32-bit words; power of two; RAM occupies bytes 0 .. RAM_WORDS*4-1
FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2
MMIO_BASE, 32'hFFFF_0000, base byte address of MMIO registers

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
MemWrite  input  1  store strobe from core; write committed at the next rising edge
Mem_WrAddr  input  32  byte address for both loads and stores; bits [1:0] ignored
Mem_WrData  input  32  store data
ReadData  output  32  combinational read data for Mem_WrAddr
tx_data  output  8  head-of-FIFO byte
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  sink accepts tx_data when tx_valid && tx_ready at a rising edge
timer_out  output  32  current timer value, for debug/trace

Behaviour:
- Decode uses word address A = Mem_WrAddr[31:2]. Regions:
  - RAM: Mem_WrAddr < RAM_WORDS*4.
  - MMIO registers, selected by Mem_WrAddr == MMIO_BASE + offset:
    - +0x0 TIMER: read = timer; write loads Mem_WrData.
    - +0x4 TXDATA: write pushes Mem_WrData[7:0]; read = 0.
    - +0x8 STATUS, read fields:
      - bit0 full;
      - bit1 empty;
      - bit2 overflow (sticky);
      - bits[15:8] occupancy count, zero-extended;
      - all other bits 0.
    - +0x8 STATUS, write (any data) clears overflow.
  - Unmapped: read = 0, write ignored, no side effects.
- RAM:
  - Asynchronous read, synchronous write of the full word when MemWrite=1.
  - Reading an address in the same cycle it is written returns the old contents; new data is visible from the next cycle.
  - RAM contents are not affected by reset.
- Timer:
  - Increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - A TIMER write takes priority over the increment: the next value is Mem_WrData exactly.
  - timer_out equals the register.
- TX FIFO:
  - Circular buffer with read/write pointers and a count of 0..FIFO_DEPTH.
  - push = MemWrite && TXDATA hit. pop = tx_valid && tx_ready.
  - tx_valid = (count != 0). tx_data = entry at the read pointer. Both come from registered state, with no combinational path from the push.
  - Push into an empty FIFO: tx_valid rises on the cycle after the write edge.
  - Simultaneous push and pop:
    - both take effect and count is unchanged;
    - this includes when the FIFO is full: the push is accepted because a slot frees on the same edge.
  - Push when full and no pop: data dropped, overflow set to 1 at that edge, pointers unchanged.
  - STATUS write on the same edge as a new overflow event: the set wins and overflow ends at 1.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset, applied at a rising edge while reset=1:
  - State after reset: timer=0, count=0, pointers=0, overflow=0.
  - Resulting outputs: tx_valid=0, tx_data=8'h00, timer_out=0.
  - ReadData follows decode of the current address; RAM reads return retained contents.
  - While reset=1, MemWrite and tx_ready are ignored; FIFO contents are discarded and RAM is not written.
  - Reset mid-stream drops all queued bytes.
- Latency:
  - Loads: 0 cycles (combinational).
  - Stores and pushes: effective at the next edge.
  - FIFO head visible 1 cycle after a push into an empty FIFO.

Test Plan:
- RAM: write 0xDEADBEEF to 0x0000_0010, then read 0x10 and 0x13 -> ReadData=0xDEADBEEF for both. Read 0x0000_1000 (RAM_WORDS=1024) -> 0. Store to 0x0000_1000 -> no RAM word changes.
- Timer: release reset and read TIMER after 5 cycles -> 5. Write 0xFFFF_FFFE -> reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0 on consecutive cycles.
- FIFO basic: tx_ready=0, push 0x41, 0x42, 0x43 -> STATUS=0x0000_0300 and tx_data=0x41. Raise tx_ready -> bytes 0x41, 0x42, 0x43 on three consecutive edges, then tx_valid=0 and STATUS=0x0000_0002.
- Full and overflow: tx_ready=0, push 9 bytes -> STATUS=0x0000_0805 and the 9th byte never appears. Write STATUS -> bit2 clears.
- Full with simultaneous push and pop: FIFO full, tx_ready=1, and a push 0x55 on the same edge -> count stays 8, overflow stays 0, and 0x55 emerges last.
- Reset mid-stream: 4 bytes queued, timer=100, assert reset for 1 cycle -> tx_valid=0, timer_out=0, STATUS=0x0000_0002, and previously written RAM words still read back.
